// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding, ID/EX Mem1 bit positions, default widths and the load-use
// match helper.
package hazard_ctrl_pkg;

  // Controller state: normal run, one-cycle post-branch squash, memory hold
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMHOLD = 2'd2
  } hz_state_e;

  // Bit positions inside the ID/EX Mem1 control field
  localparam int MEM_WRITE = 0;
  localparam int MEM_READ  = 1;
  localparam int BRANCH    = 2;

  // Default widths / limits
  localparam int CNT_W_DEFAULT       = 16;
  localparam int MEM_TIMEOUT_DEFAULT = 64;

  // A load in EX whose destination is read by the instruction in ID.
  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic load_use_match(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    return mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous
// active-low reset. Clear wins over increment in the same cycle.
module sat_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear first, then saturating increment, else hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS datapath.
// Stage-control outputs are decoded combinationally from the registered
// state and the live inputs; state, busy timer, memErr and the event
// counters are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clkHZ,
  input  logic             rstnHZ,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             branchTaken,
  input  logic             memBusy,
  input  logic             cntClr,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexWrite,
  output logic             idexBubble,
  output logic             exmemWrite,
  output logic             exmemFlush,
  output logic [CNT_W-1:0] loadUseCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] memStallCnt,
  output logic             memErr
);

  // Busy timer only has to reach MEM_TIMEOUT, then it saturates there
  localparam int                TMR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMO_VAL = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_ZERO = TMR_W'(0);

  hz_state_e        state_d;
  hz_state_e        state_q;
  hz_state_e        state_cur_s;
  logic [TMR_W-1:0] timer_d;
  logic [TMR_W-1:0] timer_q;
  logic             mem_err_d;
  logic             mem_err_q;

  logic             lu_enable_s;
  logic             lu_hit_s;
  logic             inc_load_use_s;
  logic             inc_flush_s;
  logic             inc_mem_stall_s;

  // Effective state: while reset is held the controls decode as in RUN
  always_comb begin
    state_cur_s = RUN;
    if (rstnHZ) begin
      state_cur_s = state_q;
    end else begin
      state_cur_s = RUN;
    end
  end

  // Load-use detection is masked while ID holds a squashed NOP
  always_comb begin
    lu_enable_s = 1'b1;
    case (state_cur_s)
      RUN:     lu_enable_s = 1'b1;
      MEMHOLD: lu_enable_s = 1'b1;
      FLUSH:   lu_enable_s = 1'b0;
      default: lu_enable_s = 1'b1;
    endcase
    lu_hit_s = lu_enable_s &&
               load_use_match(exMemRead, exRt, idRs, idRt, idUsesRt);
  end

  // Prioritised stage controls and next state: memBusy > branch > load-use
  always_comb begin
    pcWrite         = 1'b1;
    ifidWrite       = 1'b1;
    ifidFlush       = 1'b0;
    idexWrite       = 1'b1;
    idexBubble      = 1'b0;
    exmemWrite      = 1'b1;
    exmemFlush      = 1'b0;
    state_d         = RUN;
    inc_load_use_s  = 1'b0;
    inc_flush_s     = 1'b0;
    inc_mem_stall_s = 1'b0;
    if (memBusy) begin
      // Freeze the whole front end; a taken branch waits in EX/MEM
      pcWrite         = 1'b0;
      ifidWrite       = 1'b0;
      idexWrite       = 1'b0;
      exmemWrite      = 1'b0;
      state_d         = MEMHOLD;
      inc_mem_stall_s = 1'b1;
    end else if (branchTaken) begin
      // PC loads the target, younger instructions are squashed
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      exmemFlush  = 1'b1;
      state_d     = FLUSH;
      inc_flush_s = 1'b1;
    end else if (lu_hit_s) begin
      // Hold PC and IF/ID, inject one bubble behind the load
      pcWrite        = 1'b0;
      ifidWrite      = 1'b0;
      idexBubble     = 1'b1;
      state_d        = RUN;
      inc_load_use_s = 1'b1;
    end else begin
      state_d = RUN;
    end
  end

  // Busy timer saturates at MEM_TIMEOUT; memErr is sticky until reset
  always_comb begin
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    if (memBusy) begin
      if (timer_q == TMO_VAL) begin
        timer_d = timer_q;
      end else begin
        timer_d = timer_q + TMR_ONE;
      end
      if (timer_d == TMO_VAL) begin
        mem_err_d = 1'b1;
      end else begin
        mem_err_d = mem_err_q;
      end
    end else begin
      timer_d   = TMR_ZERO;
      mem_err_d = mem_err_q;
    end
  end

  // State, timer and error flag with synchronous active-low reset
  always_ff @(posedge clkHZ) begin
    if (!rstnHZ) begin
      state_q   <= RUN;
      timer_q   <= TMR_ZERO;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign memErr = mem_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk   (clkHZ),
    .rst_n (rstnHZ),
    .inc   (inc_load_use_s),
    .clr   (cntClr),
    .cnt   (loadUseCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clkHZ),
    .rst_n (rstnHZ),
    .inc   (inc_flush_s),
    .clr   (cntClr),
    .cnt   (flushCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_stall_cnt (
    .clk   (clkHZ),
    .rst_n (rstnHZ),
    .inc   (inc_mem_stall_s),
    .clr   (cntClr),
    .cnt   (memStallCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. u_dut uses 16-bit counters with a
// 4-cycle memory timeout; u_sat shares the inputs but has 2-bit counters
// so saturation can be reached quickly.
module tb_hazard_ctrl;

  logic       clk;
  logic       rstn;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       branch_taken;
  logic       mem_busy;
  logic       cnt_clr;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic        exmem_write, exmem_flush, mem_err;
  logic [15:0] lu_cnt, fl_cnt, ms_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write;
  logic        s_idex_bubble, s_exmem_write, s_exmem_flush, s_mem_err;
  logic [1:0]  s_lu_cnt, s_fl_cnt, s_ms_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) u_dut (
    .clkHZ(clk), .rstnHZ(rstn), .exMemRead(ex_mem_read), .exRt(ex_rt),
    .idRs(id_rs), .idRt(id_rt), .idUsesRt(id_uses_rt),
    .branchTaken(branch_taken), .memBusy(mem_busy), .cntClr(cnt_clr),
    .pcWrite(pc_write), .ifidWrite(ifid_write), .ifidFlush(ifid_flush),
    .idexWrite(idex_write), .idexBubble(idex_bubble),
    .exmemWrite(exmem_write), .exmemFlush(exmem_flush),
    .loadUseCnt(lu_cnt), .flushCnt(fl_cnt), .memStallCnt(ms_cnt),
    .memErr(mem_err)
  );

  hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64)) u_sat (
    .clkHZ(clk), .rstnHZ(rstn), .exMemRead(ex_mem_read), .exRt(ex_rt),
    .idRs(id_rs), .idRt(id_rt), .idUsesRt(id_uses_rt),
    .branchTaken(branch_taken), .memBusy(mem_busy), .cntClr(cnt_clr),
    .pcWrite(s_pc_write), .ifidWrite(s_ifid_write), .ifidFlush(s_ifid_flush),
    .idexWrite(s_idex_write), .idexBubble(s_idex_bubble),
    .exmemWrite(s_exmem_write), .exmemFlush(s_exmem_flush),
    .loadUseCnt(s_lu_cnt), .flushCnt(s_fl_cnt), .memStallCnt(s_ms_cnt),
    .memErr(s_mem_err)
  );

  // Free-running pipeline clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ex_mem_read  = 1'b0;
    ex_rt        = 5'd0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
    cnt_clr      = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    #1;
    vec_cnt++;
    if ({lu_cnt, fl_cnt, ms_cnt} !== 48'd0) begin
      err_cnt++;
      $display("FAIL reset_counters: got %h/%h/%h want 0/0/0", lu_cnt, fl_cnt, ms_cnt);
    end
    vec_cnt++;
    if (mem_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_memerr: got %b want 0", mem_err);
    end
    vec_cnt++;
    if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush} !== 7'b1101010) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 1101010",
               {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush});
    end
    // While reset is held the controls decode from RUN with live inputs
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      err_cnt++;
      $display("FAIL reset_decode_run: got %b want 001", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    idle();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_load_use_rs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_write, idex_bubble, exmem_write} !== 5'b00111) begin
      err_cnt++;
      $display("FAIL lu_rs_stall: got %b want 00111",
               {pc_write, ifid_write, idex_write, idex_bubble, exmem_write});
    end
    tick();
    ex_mem_read = 1'b0;  // load has moved to MEM
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble, lu_cnt} !== {3'b110, 16'd1}) begin
      err_cnt++;
      $display("FAIL lu_rs_release: got ctrl=%b cnt=%0d want ctrl=110 cnt=1",
               {pc_write, ifid_write, idex_bubble}, lu_cnt);
    end
    // Register 0 is never a hazard
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
      err_cnt++;
      $display("FAIL lu_r0: got %b want 110", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    vec_cnt++;
    if (lu_cnt !== 16'd1) begin
      err_cnt++;
      $display("FAIL lu_r0_cnt: got %0d want 1", lu_cnt);
    end
    idle();
  endtask

  task automatic test_load_use_rt();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      err_cnt++;
      $display("FAIL lu_rt_stall: got %b want 001", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    vec_cnt++;
    if (lu_cnt !== 16'd2) begin
      err_cnt++;
      $display("FAIL lu_rt_cnt: got %0d want 2", lu_cnt);
    end
    id_uses_rt = 1'b0;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
      err_cnt++;
      $display("FAIL lu_rt_unused: got %b want 110", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    vec_cnt++;
    if (lu_cnt !== 16'd2) begin
      err_cnt++;
      $display("FAIL lu_rt_unused_cnt: got %0d want 2", lu_cnt);
    end
    idle();
  endtask

  task automatic test_branch();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b11111) begin
      err_cnt++;
      $display("FAIL br_ctrl: got %b want 11111",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    end
    tick();
    vec_cnt++;
    if ({lu_cnt, fl_cnt} !== {16'd2, 16'd1}) begin
      err_cnt++;
      $display("FAIL br_cnt: got lu=%0d fl=%0d want lu=2 fl=1", lu_cnt, fl_cnt);
    end
    // In FLUSH the load-use match is ignored
    branch_taken = 1'b0;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100) begin
      err_cnt++;
      $display("FAIL br_flush_mask: got %b want 1100",
               {pc_write, ifid_write, idex_bubble, ifid_flush});
    end
    tick();
    vec_cnt++;
    if (lu_cnt !== 16'd2) begin
      err_cnt++;
      $display("FAIL br_flush_lu_cnt: got %0d want 2", lu_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_mem_busy();
    mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++;
      if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, exmem_flush} !== 7'b0000000) begin
        err_cnt++;
        $display("FAIL busy_ctrl[%0d]: got %b want 0000000", i,
                 {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, exmem_flush});
      end
      tick();
    end
    vec_cnt++;
    if ({ms_cnt, fl_cnt, mem_err} !== {16'd5, 16'd1, 1'b1}) begin
      err_cnt++;
      $display("FAIL busy_cnt: got ms=%0d fl=%0d err=%b want ms=5 fl=1 err=1", ms_cnt, fl_cnt, mem_err);
    end
    mem_busy = 1'b0;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_flush, idex_bubble, exmem_flush} !== 4'b1111) begin
      err_cnt++;
      $display("FAIL busy_release_flush: got %b want 1111",
               {pc_write, ifid_flush, idex_bubble, exmem_flush});
    end
    tick();
    vec_cnt++;
    if (fl_cnt !== 16'd2) begin
      err_cnt++;
      $display("FAIL busy_release_cnt: got %0d want 2", fl_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_busy = 1'b1;
    tick(); tick(); tick();
    vec_cnt++;
    if (mem_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL tmo_3cyc: got %b want 0", mem_err);
    end
    tick();
    vec_cnt++;
    if (mem_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL tmo_4cyc: got %b want 1", mem_err);
    end
    mem_busy = 1'b0;
    tick();
    vec_cnt++;
    if (mem_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL tmo_sticky: got %b want 1", mem_err);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    vec_cnt++;
    if ({mem_err, ms_cnt} !== {1'b1, 16'd0}) begin
      err_cnt++;
      $display("FAIL tmo_cntclr: got err=%b ms=%0d want err=1 ms=0", mem_err, ms_cnt);
    end
    do_reset();
    vec_cnt++;
    if (mem_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL tmo_reset: got %b want 0", mem_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vec_cnt++;
    if ({s_fl_cnt, fl_cnt} !== {2'd3, 16'd4}) begin
      err_cnt++;
      $display("FAIL sat_flush: got sat=%0d wide=%0d want sat=3 wide=4", s_fl_cnt, fl_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    vec_cnt++;
    if ({s_fl_cnt, fl_cnt} !== {2'd0, 16'd0}) begin
      err_cnt++;
      $display("FAIL sat_clr_prio: got sat=%0d wide=%0d want 0/0", s_fl_cnt, fl_cnt);
    end
    tick();  // one more flush event, now sitting in FLUSH
    branch_taken = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    vec_cnt++;
    if ({s_fl_cnt, fl_cnt, lu_cnt, ms_cnt} !== {2'd0, 48'd0}) begin
      err_cnt++;
      $display("FAIL rst_in_flush_cnt: got sat=%0d fl=%0d lu=%0d ms=%0d want all 0",
               s_fl_cnt, fl_cnt, lu_cnt, ms_cnt);
    end
    // Back in RUN: a load-use stalls (it would be masked in FLUSH)
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    vec_cnt++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      err_cnt++;
      $display("FAIL rst_in_flush_run: got %b want 001", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    idle();
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    test_reset();
    test_load_use_rs();
    test_load_use_rt();
    test_branch();
    test_mem_busy();
    test_timeout();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS datapath. It reads the outputs of the ID/EX register, the current IF/ID instruction fields, the MEM-stage branch outcome and the data-memory busy flag. It drives the write-enable, bubble and flush controls back into the PC, IF/ID, ID/EX and EX/MEM stages. It also keeps saturating event counters and a sticky memory-timeout error.

Parameters:
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 64, maximum consecutive memBusy cycles before memErr sets (must be ≥1)

Ports:
clkHZ  in  1  pipeline clock
rstnHZ  in  1  synchronous active-low reset
exMemRead  in  1  MemRead bit of the instruction in EX (ID/EX Mem1[1])
exRt  in  5  Rt field of the instruction in EX (load destination, ID/EX tMux5_1)
idRs  in  5  Rs field of the instruction in ID (IF/ID)
idRt  in  5  Rt field of the instruction in ID
idUsesRt  in  1  ID instruction reads Rt as a source (R-type, store, beq)
branchTaken  in  1  branch resolved taken in MEM
memBusy  in  1  data memory not ready this cycle
cntClr  in  1  synchronous clear of all counters
pcWrite  out  1  PC update enable
ifidWrite  out  1  IF/ID load enable
ifidFlush  out  1  IF/ID load NOP
idexWrite  out  1  ID/EX load enable
idexBubble  out  1  ID/EX load zeroed WB/M/EX control fields
exmemWrite  out  1  EX/MEM load enable
exmemFlush  out  1  EX/MEM load zeroed control fields
loadUseCnt  out  CNT_W  load-use stall events
flushCnt  out  CNT_W  taken-branch flush events
memStallCnt  out  CNT_W  memBusy cycles
memErr  out  1  sticky: memBusy lasted ≥ MEM_TIMEOUT consecutive cycles

Behaviour:
- Reset (rstnHZ=0 at posedge): state=RUN, all counters=0, busy timer=0, memErr=0. While reset is held, control outputs decode from RUN with the current inputs. Reset mid-stall or mid-flush returns to RUN with no pending action.
- Control outputs are combinational from the registered state and the current inputs. State, counters and memErr are registered.
- Default, when no condition holds: all *Write=1; all flush/bubble=0.
- Condition priority, highest first:
  1. memBusy
  2. branchTaken
  3. load-use
- memBusy=1: pcWrite=ifidWrite=idexWrite=exmemWrite=0; no flush or bubble. The next state is MEMHOLD. The busy timer increments, saturating at MEM_TIMEOUT, and memErr sets when the timer reaches MEM_TIMEOUT. memStallCnt+1. A pending branchTaken is not acted on, because EX/MEM holds and branchTaken stays asserted.
- branchTaken=1 with memBusy=0: pcWrite=1, which loads the branch target. ifidFlush=1, idexBubble=1, exmemFlush=1. flushCnt+1. The next state is FLUSH.
- Load-use: exMemRead & exRt≠0 & (exRt==idRs | (idUsesRt & exRt==idRt)), evaluated only in RUN or MEMHOLD. Response: pcWrite=0, ifidWrite=0, idexBubble=1. loadUseCnt+1, once per event. A load-use stall is exactly 1 cycle: after the bubble, the load is in MEM and exMemRead=0.
- FLUSH state, lasting 1 cycle: the ID stage holds a squashed NOP, so load-use detection is masked. memBusy and branchTaken are still honoured under the same priority. Otherwise the next state is RUN.
- MEMHOLD: the state persists while memBusy=1. On memBusy=0 the busy timer clears, memErr stays set, and the conditions are re-evaluated in the same cycle.
- Counters saturate at all-ones. cntClr zeroes all counters and takes priority over any increment in that cycle; it does not clear memErr.
- Register 0 is never a hazard.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, FLUSH=2'd1, MEMHOLD=2'd2
  - Mem1 bit index constants: MEM_READ=1, MEM_WRITE=0, BRANCH=2
  - the CNT_W default
- One natural sub-module: sat_counter (CNT_W-wide, with inc, clr, synchronous active-low reset), instantiated three times.

Test Plan:
- Load-use on Rs: exMemRead=1, exRt=8, idRs=8 -> pcWrite=0, ifidWrite=0, idexBubble=1 for 1 cycle; loadUseCnt=1. Same with exRt=0 -> no stall.
- Load-use on Rt: idUsesRt=1, idRt=9, exRt=9 -> stall. Same with idUsesRt=0 -> no stall, loadUseCnt unchanged.
- Branch with simultaneous load-use: branchTaken=1 -> ifidFlush=idexBubble=exmemFlush=1, pcWrite=1, loadUseCnt unchanged, flushCnt=1. The next cycle is in FLUSH and a load-use match is ignored.
- memBusy for 5 cycles with branchTaken held -> all *Write=0 for 5 cycles, memStallCnt=5, no flush. The flush fires on the cycle memBusy drops.
- memBusy held for MEM_TIMEOUT=4 cycles (override) -> memErr=1 after the 4th cycle. It stays 1 after memBusy drops and after cntClr; it clears only on rstnHZ=0.
- Counter saturation (CNT_W=2) and cntClr: 4 flushes -> flushCnt=3. cntClr concurrent with an event -> 0. rstnHZ=0 during a FLUSH state -> RUN, all counters 0.
